// File: rtl/adc96_lane_capture.sv
// ADC96 lane capture engine: selects one 36-bit lane word and bursts it into the capture SRAM.
// Optional threshold trigger compiled in with ADC96_CAP_TRIG_EN.
module adc96_lane_capture #(
    parameter int ADDR_W = 12
) (
    input  logic              ANA_ADC_CLK500M,
    input  logic              adc96_rstn,
    input  logic [35:0]       ANA_ADC_DATA_0,
    input  logic [35:0]       ANA_ADC_DATA_1,
    input  logic [35:0]       ANA_ADC_DATA_2,
    input  logic [35:0]       ANA_ADC_DATA_3,
    input  logic [35:0]       ANA_ADC_DATA_4,
    input  logic [35:0]       ANA_ADC_DATA_5,
    input  logic [35:0]       ANA_ADC_DATA_6,
    input  logic [35:0]       ANA_ADC_DATA_7,
    input  logic [35:0]       ANA_ADC_DATA_8,
    input  logic [35:0]       ANA_ADC_DATA_9,
    input  logic [35:0]       ANA_ADC_DATA_10,
    input  logic [35:0]       ANA_ADC_DATA_11,
    input  logic [35:0]       ANA_ADC_DATA_12,
    input  logic [35:0]       ANA_ADC_DATA_13,
    input  logic [35:0]       ANA_ADC_DATA_14,
    input  logic [35:0]       ANA_ADC_DATA_15,
    input  logic [35:0]       ANA_ADC_DATA_16,
    input  logic [35:0]       ANA_ADC_DATA_17,
    input  logic [35:0]       ANA_ADC_DATA_18,
    input  logic [35:0]       ANA_ADC_DATA_19,
    input  logic [35:0]       ANA_ADC_DATA_20,
    input  logic [35:0]       ANA_ADC_DATA_21,
    input  logic [35:0]       ANA_ADC_DATA_22,
    input  logic [35:0]       ANA_ADC_DATA_23,
    input  logic [4:0]        cap_lane_sel,
    input  logic [ADDR_W-1:0] cap_len,
    input  logic              cap_arm,
    input  logic              cap_abort,
    input  logic [8:0]        trig_thresh,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [35:0]       mem_wr_data,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              cap_err,
    output logic [ADDR_W:0]   cap_wr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t            state_r;
    logic [4:0]        sel_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] addr_r;
    logic [35:0]       lane_q_r;
    logic              lane_vld_r;
    logic              mem_wr_en_r;
    logic [ADDR_W-1:0] mem_wr_addr_r;
    logic [35:0]       mem_wr_data_r;
    logic              cap_busy_r;
    logic              cap_done_r;
    logic              cap_err_r;
    logic [ADDR_W:0]   cap_wr_cnt_r;

    logic [35:0]       lanes_s [24];
    logic [35:0]       lane_mux_s;
    logic              hit_s;
    logic              fire_s;
    logic              last_s;

    assign lanes_s[0]  = ANA_ADC_DATA_0;
    assign lanes_s[1]  = ANA_ADC_DATA_1;
    assign lanes_s[2]  = ANA_ADC_DATA_2;
    assign lanes_s[3]  = ANA_ADC_DATA_3;
    assign lanes_s[4]  = ANA_ADC_DATA_4;
    assign lanes_s[5]  = ANA_ADC_DATA_5;
    assign lanes_s[6]  = ANA_ADC_DATA_6;
    assign lanes_s[7]  = ANA_ADC_DATA_7;
    assign lanes_s[8]  = ANA_ADC_DATA_8;
    assign lanes_s[9]  = ANA_ADC_DATA_9;
    assign lanes_s[10] = ANA_ADC_DATA_10;
    assign lanes_s[11] = ANA_ADC_DATA_11;
    assign lanes_s[12] = ANA_ADC_DATA_12;
    assign lanes_s[13] = ANA_ADC_DATA_13;
    assign lanes_s[14] = ANA_ADC_DATA_14;
    assign lanes_s[15] = ANA_ADC_DATA_15;
    assign lanes_s[16] = ANA_ADC_DATA_16;
    assign lanes_s[17] = ANA_ADC_DATA_17;
    assign lanes_s[18] = ANA_ADC_DATA_18;
    assign lanes_s[19] = ANA_ADC_DATA_19;
    assign lanes_s[20] = ANA_ADC_DATA_20;
    assign lanes_s[21] = ANA_ADC_DATA_21;
    assign lanes_s[22] = ANA_ADC_DATA_22;
    assign lanes_s[23] = ANA_ADC_DATA_23;

`ifdef ADC96_CAP_TRIG_EN
    function automatic logic word_hit(input logic [35:0] word, input logic [8:0] thresh);
        logic h;
        h = 1'b0;
        for (int k = 0; k < 4; k++) begin
            h = h | (word[9*k +: 9] >= thresh);
        end
        return h;
    endfunction

    assign hit_s = word_hit(lane_q_r, trig_thresh);
`else
    logic unused_thresh_s;
    assign unused_thresh_s = ^trig_thresh;
    assign hit_s           = 1'b1;
`endif

    // Lane select mux; sel_r never exceeds 23, unmatched codes yield zero.
    always_comb begin
        lane_mux_s = 36'd0;
        for (int i = 0; i < 24; i++) begin
            lane_mux_s = (sel_r == 5'(i)) ? lanes_s[i] : lane_mux_s;
        end
    end

    // lane_vld_r marks lane_q_r as holding a word of the newly latched lane.
    assign fire_s = (state_r == ST_CAPTURE) || ((state_r == ST_ARMED) && lane_vld_r && hit_s);
    assign last_s = (cap_wr_cnt_r == {1'b0, len_r});

    // Lane word pipeline register.
    always_ff @(posedge ANA_ADC_CLK500M or negedge adc96_rstn) begin
        if (!adc96_rstn) begin
            lane_q_r <= 36'd0;
        end else begin
            lane_q_r <= lane_mux_s;
        end
    end

    // Capture FSM with registered SRAM strobe, status flags and counters.
    always_ff @(posedge ANA_ADC_CLK500M or negedge adc96_rstn) begin
        if (!adc96_rstn) begin
            state_r       <= ST_IDLE;
            sel_r         <= 5'd0;
            len_r         <= '0;
            addr_r        <= '0;
            lane_vld_r    <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_wr_addr_r <= '0;
            mem_wr_data_r <= 36'd0;
            cap_busy_r    <= 1'b0;
            cap_done_r    <= 1'b0;
            cap_err_r     <= 1'b0;
            cap_wr_cnt_r  <= '0;
        end else begin
            mem_wr_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    lane_vld_r <= 1'b0;
                    if (cap_abort) begin
                        state_r <= ST_IDLE;
                    end else if (cap_arm && (cap_lane_sel <= 5'd23)) begin
                        state_r      <= ST_ARMED;
                        sel_r        <= cap_lane_sel;
                        len_r        <= cap_len;
                        addr_r       <= '0;
                        cap_wr_cnt_r <= '0;
                        cap_done_r   <= 1'b0;
                        cap_err_r    <= 1'b0;
                        cap_busy_r   <= 1'b1;
                    end else if (cap_arm) begin
                        cap_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    lane_vld_r <= 1'b1;
                    if (cap_abort) begin
                        state_r    <= ST_IDLE;
                        cap_busy_r <= 1'b0;
                    end else if (fire_s) begin
                        mem_wr_en_r   <= 1'b1;
                        mem_wr_addr_r <= addr_r;
                        mem_wr_data_r <= lane_q_r;
                        addr_r        <= addr_r + ADDR_W'(1);
                        cap_wr_cnt_r  <= cap_wr_cnt_r + (ADDR_W+1)'(1);
                        if (last_s) begin
                            state_r    <= ST_IDLE;
                            cap_done_r <= 1'b1;
                            cap_busy_r <= 1'b0;
                        end else begin
                            state_r <= ST_CAPTURE;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cap_busy_r <= 1'b0;
                    lane_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_wr_en   = mem_wr_en_r;
    assign mem_wr_addr = mem_wr_addr_r;
    assign mem_wr_data = mem_wr_data_r;
    assign cap_busy    = cap_busy_r;
    assign cap_done    = cap_done_r;
    assign cap_err     = cap_err_r;
    assign cap_wr_cnt  = cap_wr_cnt_r;

endmodule

// File: tb/tb_adc96_lane_capture.sv
// Directed bench for adc96_lane_capture (ADDR_W=4) with a write scoreboard.
// Trigger scenario is exercised only when ADC96_CAP_TRIG_EN is defined.
module tb_adc96_lane_capture;

    localparam int AW = 4;

    logic          clk;
    logic          rstn;
    logic [35:0]   lanes [24];
    logic [4:0]    cap_lane_sel;
    logic [AW-1:0] cap_len;
    logic          cap_arm;
    logic          cap_abort;
    logic [8:0]    trig_thresh;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [35:0]   mem_wr_data;
    logic          cap_busy;
    logic          cap_done;
    logic          cap_err;
    logic [AW:0]   cap_wr_cnt;

    int            checks;
    int            failures;
    int            cyc;
    logic [39:0]   sb [$];
    logic          trig_mode;
    int            trig_cyc;

    adc96_lane_capture #(.ADDR_W(AW)) dut (
        .ANA_ADC_CLK500M(clk),
        .adc96_rstn(rstn),
        .ANA_ADC_DATA_0(lanes[0]),   .ANA_ADC_DATA_1(lanes[1]),
        .ANA_ADC_DATA_2(lanes[2]),   .ANA_ADC_DATA_3(lanes[3]),
        .ANA_ADC_DATA_4(lanes[4]),   .ANA_ADC_DATA_5(lanes[5]),
        .ANA_ADC_DATA_6(lanes[6]),   .ANA_ADC_DATA_7(lanes[7]),
        .ANA_ADC_DATA_8(lanes[8]),   .ANA_ADC_DATA_9(lanes[9]),
        .ANA_ADC_DATA_10(lanes[10]), .ANA_ADC_DATA_11(lanes[11]),
        .ANA_ADC_DATA_12(lanes[12]), .ANA_ADC_DATA_13(lanes[13]),
        .ANA_ADC_DATA_14(lanes[14]), .ANA_ADC_DATA_15(lanes[15]),
        .ANA_ADC_DATA_16(lanes[16]), .ANA_ADC_DATA_17(lanes[17]),
        .ANA_ADC_DATA_18(lanes[18]), .ANA_ADC_DATA_19(lanes[19]),
        .ANA_ADC_DATA_20(lanes[20]), .ANA_ADC_DATA_21(lanes[21]),
        .ANA_ADC_DATA_22(lanes[22]), .ANA_ADC_DATA_23(lanes[23]),
        .cap_lane_sel(cap_lane_sel),
        .cap_len(cap_len),
        .cap_arm(cap_arm),
        .cap_abort(cap_abort),
        .trig_thresh(trig_thresh),
        .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .cap_busy(cap_busy),
        .cap_done(cap_done),
        .cap_err(cap_err),
        .cap_wr_cnt(cap_wr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [35:0] pat(input int lane, input int c);
        return {5'(lane), 31'(c * 7 + 3)};
    endfunction

    function automatic logic [35:0] lane0_trig_word(input int c);
        logic [35:0] w;
        w = {9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF};
        if (c == trig_cyc) w[26:18] = 9'h100;
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 24; i++) lanes[i] = pat(i, cyc);
        if (trig_mode) lanes[0] = lane0_trig_word(cyc);
    endtask

    // Arm a burst now; first captured word is the lane input of the following cycle.
    task automatic burst(input int sel, input int len);
        int k;
        k = cyc;
        cap_lane_sel = 5'(sel);
        cap_len      = AW'(len);
        cap_arm      = 1'b1;
        for (int j = 0; j <= len; j++) sb.push_back({AW'(j), pat(sel, k + 1 + j)});
        tick();
        cap_arm = 1'b0;
        check("busy_rise", cap_busy, 1);
        check("err_clear", cap_err, 0);
        repeat (len + 1) tick();
        check("done_before_last", cap_done, 0);
        tick();
        check("last_wr_en", mem_wr_en, 1);
        check("done_with_last", cap_done, 1);
        check("busy_fall_with_last", cap_busy, 0);
        check("wr_cnt", cap_wr_cnt, len + 1);
        tick();
        check("wr_en_after_last", mem_wr_en, 0);
    endtask

    // Write scoreboard: every strobe must match the next expected {addr, data}.
    initial begin
        logic [39:0] exp_w;
        forever begin
            @(negedge clk);
            if (rstn && mem_wr_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", mem_wr_en, 0);
                end else begin
                    exp_w = sb.pop_front();
                    check("write", {mem_wr_addr, mem_wr_data}, exp_w);
                end
            end
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        trig_mode    = 1'b0;
        trig_cyc     = -1;
        rstn         = 1'b0;
        cap_lane_sel = 5'd0;
        cap_len      = '0;
        cap_arm      = 1'b0;
        cap_abort    = 1'b0;
        trig_thresh  = 9'd0;
        for (int i = 0; i < 24; i++) lanes[i] = pat(i, 0);
        #2;
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_wr_addr, 0);
        check("rst_data", mem_wr_data, 0);
        check("rst_busy", cap_busy, 0);
        check("rst_done", cap_done, 0);
        check("rst_err", cap_err, 0);
        check("rst_cnt", cap_wr_cnt, 0);
        tick();
        rstn = 1'b1;
        repeat (2) tick();

        burst(5, 3);

        // Arm and abort together in IDLE: nothing changes.
        cap_lane_sel = 5'd1;
        cap_arm      = 1'b1;
        cap_abort    = 1'b1;
        tick();
        cap_arm   = 1'b0;
        cap_abort = 1'b0;
        tick();
        check("arm_abort_busy", cap_busy, 0);
        check("arm_abort_done", cap_done, 1);
        check("arm_abort_cnt", cap_wr_cnt, 4);

        // Out-of-range lane select.
        cap_lane_sel = 5'd24;
        cap_arm      = 1'b1;
        tick();
        cap_arm = 1'b0;
        check("bad_sel_err", cap_err, 1);
        check("bad_sel_busy", cap_busy, 0);
        tick();
        check("bad_sel_busy2", cap_busy, 0);
        burst(2, 3);

        // Abort after three writes of an eight-word burst.
        cap_lane_sel = 5'd7;
        cap_len      = AW'(7);
        cap_arm      = 1'b1;
        for (int j = 0; j < 3; j++) sb.push_back({AW'(j), pat(7, cyc + 1 + j)});
        tick();
        cap_arm = 1'b0;
        repeat (4) tick();
        cap_abort = 1'b1;
        tick();
        cap_abort = 1'b0;
        check("abort_wr_en", mem_wr_en, 0);
        check("abort_busy", cap_busy, 0);
        check("abort_done", cap_done, 0);
        check("abort_cnt", cap_wr_cnt, 3);
        repeat (4) tick();

        // Asynchronous reset in the middle of a burst.
        cap_lane_sel = 5'd23;
        cap_len      = AW'(15);
        cap_arm      = 1'b1;
        for (int j = 0; j < 16; j++) sb.push_back({AW'(j), pat(23, cyc + 1 + j)});
        tick();
        cap_arm = 1'b0;
        repeat (4) tick();
        rstn = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_wr_en", mem_wr_en, 0);
        check("mid_rst_addr", mem_wr_addr, 0);
        check("mid_rst_data", mem_wr_data, 0);
        check("mid_rst_busy", cap_busy, 0);
        check("mid_rst_cnt", cap_wr_cnt, 0);
        tick();
        rstn = 1'b1;
        tick();

        // Full-depth burst after reset: addresses 0..15, count 16.
        burst(23, 15);

`ifdef ADC96_CAP_TRIG_EN
        // Threshold trigger on sample 2 of lane 0 ten cycles after arm.
        trig_thresh = 9'h100;
        trig_mode   = 1'b1;
        trig_cyc    = cyc + 10;
        tick();
        cap_lane_sel = 5'd0;
        cap_len      = AW'(3);
        cap_arm      = 1'b1;
        for (int j = 0; j < 4; j++) sb.push_back({AW'(j), lane0_trig_word(trig_cyc + j)});
        tick();
        cap_arm = 1'b0;
        while (cyc < trig_cyc + 5) tick();
        check("trig_done", cap_done, 1);
        check("trig_cnt", cap_wr_cnt, 4);
        trig_mode   = 1'b0;
        trig_thresh = 9'd0;
        repeat (2) tick();
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
